muldiv_sequencer: RTL

- Iterative multiply/divide controller beside the EX-stage ALU. It owns the HI/LO register pair and executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- It sequences a shared shift-add/restoring-subtract datapath over WIDTH cycles and raises a stall to the hazard unit while an operation is in flight.
- The single-cycle ALU path is untouched. This block handles only HI/LO-class R-type functs.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_iter_core.sv | 35 +++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Funct codes, FSM encoding and funct-class helpers.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // 0x10..0x13 and 0x18..0x1B
  function automatic logic is_hilo(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

  function automatic logic is_md(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational iteration of the shared datapath:
// shift-add multiply or restoring-subtract divide.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd})
                     : {1'b0, acc_hi};
    // remainder needs one extra bit before the compare
    shl  = {acc_hi, acc_lo[WIDTH-1]};
    ge   = shl >= {1'b0, opnd};
    diff = shl[WIDTH-1:0] - opnd;
    if (is_div) begin
      nxt_hi = ge ? diff : shl[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and iterative mult/div controller beside the EX ALU.
// Magnitudes are iterated; signs are applied in the FIXUP cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mf_data
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic               hilo_op;
  logic               md_op;
  logic               sgn_op;
  logic               div_op;
  logic               sgn_x;

  always_comb begin
    hilo_op  = is_hilo(funct);
    md_op    = is_md(funct);
    sgn_op   = md_op & ~funct[0];
    div_op   = funct[1];
    sgn_x    = sgn_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
    rs_abs   = (sgn_op & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_abs   = (sgn_op & rt_val[WIDTH-1]) ? -rt_val : rt_val;
    prod     = {acc_hi, acc_lo};
    prod_neg = -prod;
  end

  assign stall   = op_valid & hilo_op & (state != IDLE);
  assign mf_data = (funct == FN_MFHI) ? hi : lo;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (op_valid) begin
              unique case (1'b1)
                (funct == FN_MTHI): hi <= rs_val;
                (funct == FN_MTLO): lo <= rs_val;
                md_op: begin
                  is_div <= div_op;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  if (div_op && rt_val == '0) begin
                    // divide by zero bypasses iteration
                    acc_hi <= rs_val;
                    acc_lo <= '1;
                    neg_q  <= 1'b0;
                    neg_r  <= 1'b0;
                    state  <= FIXUP;
                  end else if (div_op) begin
                    acc_hi <= '0;
                    acc_lo <= rs_abs;
                    opnd   <= rt_abs;
                    neg_q  <= sgn_x;
                    neg_r  <= sgn_op & rs_val[WIDTH-1];
                    state  <= RUN;
                  end else begin
                    acc_hi <= '0;
                    acc_lo <= rt_abs;
                    opnd   <= rs_abs;
                    neg_q  <= sgn_x;
                    neg_r  <= 1'b0;
                    state  <= RUN;
                  end
                end
                default: ;
              endcase
            end
          end
          RUN: begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
          end
          FIXUP: begin
            if (is_div) begin
              hi <= neg_r ? -acc_hi : acc_hi;
              lo <= neg_q ? -acc_lo : acc_lo;
            end else if (neg_q) begin
              {hi, lo} <= prod_neg;
            end else begin
              {hi, lo} <= prod;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
